// File: rtl/hilihase_drive_sequencer.sv
// rtl/hilihase_drive_sequencer.sv - timestamped drive-command sequencer for the hilihase co-sim link
//
// Buffers {time, id, value} drive commands from the host bridge in a small FIFO
// and applies each to its DUT input once the internal timeslot counter reaches
// the command time. A command with id 0 ends the test.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse; leaves IDLE and starts the timeslot counter
//   cmd_valid/cmd_ready command handshake; cmd_time, cmd_id, cmd_val payload
//   drv_val, drv_oe     per-signal driven value / output enable (bit i-1 = id i)
//   time_now            current timeslot
//   apply_valid/apply_id one-cycle pulse and id of each applied command
//   busy, done          RUN / DONE state indicators
//   err_id, err_x, err_late  sticky error flags
module hilihase_drive_sequencer #(
    parameter int NUM_SIG = 8,
    parameter int ID_W    = 8,
    parameter int TIME_W  = 32,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TIME_W-1:0]   cmd_time,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [1:0]          cmd_val,
    output logic [NUM_SIG-1:0]  drv_val,
    output logic [NUM_SIG-1:0]  drv_oe,
    output logic [TIME_W-1:0]   time_now,
    output logic                apply_valid,
    output logic [ID_W-1:0]     apply_id,
    output logic                busy,
    output logic                done,
    output logic                err_id,
    output logic                err_x,
    output logic                err_late
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   fifo_time_q [DEPTH];
    logic [TIME_W-1:0]   fifo_time_d [DEPTH];
    logic [ID_W-1:0]     fifo_id_q   [DEPTH];
    logic [ID_W-1:0]     fifo_id_d   [DEPTH];
    logic [1:0]          fifo_val_q  [DEPTH];
    logic [1:0]          fifo_val_d  [DEPTH];
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [NUM_SIG-1:0]  drv_val_q, drv_val_d, drv_oe_q, drv_oe_d;
    logic [TIME_W-1:0]   time_now_q, time_now_d;
    logic                apply_valid_q, apply_valid_d;
    logic [ID_W-1:0]     apply_id_q, apply_id_d;
    logic                err_id_q, err_id_d, err_x_q, err_x_d, err_late_q, err_late_d;

    logic                fifo_full, fifo_empty, push, pop;
    logic [TIME_W-1:0]   head_time;
    logic [ID_W-1:0]     head_id;
    logic [1:0]          head_val;

    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_time  = fifo_time_q[rd_ptr_q];
    assign head_id    = fifo_id_q[rd_ptr_q];
    assign head_val   = fifo_val_q[rd_ptr_q];

    assign cmd_ready  = !fifo_full && (state_q != S_DONE);
    assign push       = cmd_valid && cmd_ready;
    // A due head is popped instead of advancing time, so equal-time commands
    // drain back-to-back at the same time_now.
    assign pop        = (state_q == S_RUN) && !fifo_empty && (head_time <= time_now_q);

    always_comb begin
        state_d       = state_q;
        fifo_time_d   = fifo_time_q;
        fifo_id_d     = fifo_id_q;
        fifo_val_d    = fifo_val_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        drv_val_d     = drv_val_q;
        drv_oe_d      = drv_oe_q;
        time_now_d    = time_now_q;
        apply_valid_d = 1'b0;
        apply_id_d    = apply_id_q;
        err_id_d      = err_id_q;
        err_x_d       = err_x_q;
        err_late_d    = err_late_q;

        if (push) begin
            fifo_time_d[wr_ptr_q] = cmd_time;
            fifo_id_d[wr_ptr_q]   = cmd_id;
            fifo_val_d[wr_ptr_q]  = cmd_val;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (head_time < time_now_q) begin
                        err_late_d = 1'b1;
                    end
                    // Stop outranks every value check; id range is checked before x.
                    if (head_id == '0) begin
                        state_d = S_DONE;
                    end else if (head_id > ID_W'(NUM_SIG)) begin
                        err_id_d = 1'b1;
                    end else if (head_val == 2'd2) begin
                        err_x_d = 1'b1;
                    end else begin
                        apply_valid_d = 1'b1;
                        apply_id_d    = head_id;
                        for (int i = 0; i < NUM_SIG; i++) begin
                            if (head_id == ID_W'(i + 1)) begin
                                if (head_val == 2'd3) begin
                                    drv_oe_d[i] = 1'b0;
                                end else begin
                                    drv_val_d[i] = head_val[0];
                                    drv_oe_d[i]  = 1'b1;
                                end
                            end
                        end
                    end
                end else if (time_now_q != '1) begin
                    time_now_d = time_now_q + TIME_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_time_q[i] <= '0;
                fifo_id_q[i]   <= '0;
                fifo_val_q[i]  <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            drv_val_q     <= '0;
            drv_oe_q      <= '1;
            time_now_q    <= '0;
            apply_valid_q <= 1'b0;
            apply_id_q    <= '0;
            err_id_q      <= 1'b0;
            err_x_q       <= 1'b0;
            err_late_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fifo_time_q   <= fifo_time_d;
            fifo_id_q     <= fifo_id_d;
            fifo_val_q    <= fifo_val_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            drv_val_q     <= drv_val_d;
            drv_oe_q      <= drv_oe_d;
            time_now_q    <= time_now_d;
            apply_valid_q <= apply_valid_d;
            apply_id_q    <= apply_id_d;
            err_id_q      <= err_id_d;
            err_x_q       <= err_x_d;
            err_late_q    <= err_late_d;
        end
    end

    assign drv_val     = drv_val_q;
    assign drv_oe      = drv_oe_q;
    assign time_now    = time_now_q;
    assign apply_valid = apply_valid_q;
    assign apply_id    = apply_id_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign err_id      = err_id_q;
    assign err_x       = err_x_q;
    assign err_late    = err_late_q;

endmodule
